// File: rtl/fft_ctrl_pkg.sv
// Shared constants, FSM state encoding and the bit-reversal helper for the
// 64-point in-place FFT controller.
package fft_ctrl_pkg;
  localparam int LOG2N = 6;
  localparam int N     = 64;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD, FLUSH} state_t;

  function automatic logic [5:0] bitrev6(input logic [5:0] v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[5-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT butterfly addressing: stage/k to operand pair and twiddle index.
module fft_addr_gen (
  input  logic [2:0] stage,
  input  logic [4:0] k,
  output logic [5:0] addr_a,
  output logic [5:0] addr_b,
  output logic [4:0] tw_idx
);
  logic [5:0] span, pos, grp;

  always_comb begin
    span   = 6'd1 << stage;
    pos    = {1'b0, k} & (span - 6'd1);
    grp    = {1'b0, k} >> stage;
    // grp*2*span + pos, expressed as a shift since span is a power of two
    addr_a = (grp << (stage + 3'd1)) | pos;
    addr_b = addr_a + span;
    tw_idx = pos[4:0] << (3'd5 - stage);
  end
endmodule

// File: rtl/inplace_fft_ctrl.sv
// Sequencer for a 64-point in-place FFT: bit-reversed load, six butterfly
// stages with write-back delay line, then paired unload reads.
module inplace_fft_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int BF_LAT = 3,
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       load_wr_en,
  output logic [5:0] load_addr,
  output logic       bf_rd_en,
  output logic [5:0] bf_addr_a,
  output logic [5:0] bf_addr_b,
  output logic [4:0] tw_idx,
  output logic       bf_wr_en,
  output logic [5:0] bf_wr_addr_a,
  output logic [5:0] bf_wr_addr_b,
  output logic [2:0] stage,
  output logic       unload_rd_en,
  output logic [5:0] unload_addr0,
  output logic [5:0] unload_addr1,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);
  state_t     state;
  logic [5:0] cnt;
  logic [2:0] stage_q;

  logic [BF_LAT-1:0]      bf_vld_pipe;
  logic [BF_LAT-1:0][5:0] wa_pipe, wb_pipe;
  logic [RD_LAT-1:0]      rd_vld_pipe;

  logic [5:0] ga, gb;
  logic [4:0] gtw;

  fft_addr_gen u_addr (
    .stage  (stage_q),
    .k      (cnt[4:0]),
    .addr_a (ga),
    .addr_b (gb),
    .tw_idx (gtw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      stage_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          stage_q <= '0;
          if (start) state <= LOAD;
        end
        LOAD: if (in_valid) begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'd63) state <= COMPUTE;
        end
        COMPUTE: begin
          cnt <= (cnt == 6'd31) ? 6'd0 : cnt + 6'd1;
          if (cnt == 6'd31) state <= DRAIN;
        end
        DRAIN: begin
          if (cnt == 6'(BF_LAT - 1)) begin
            cnt <= '0;
            if (stage_q == 3'd5) state <= UNLOAD;
            else begin
              stage_q <= stage_q + 3'd1;
              state   <= COMPUTE;
            end
          end else cnt <= cnt + 6'd1;
        end
        UNLOAD: begin
          cnt <= (cnt == 6'd31) ? 6'd0 : cnt + 6'd1;
          if (cnt == 6'd31) state <= FLUSH;
        end
        FLUSH: begin
          if (cnt == 6'(RD_LAT - 1)) begin
            cnt     <= '0;
            stage_q <= '0;
            state   <= IDLE;
          end else cnt <= cnt + 6'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay lines carry already-gated values, so idle slots shift zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      bf_vld_pipe <= '0;
      wa_pipe     <= '0;
      wb_pipe     <= '0;
      rd_vld_pipe <= '0;
    end else begin
      bf_vld_pipe[0] <= bf_rd_en;
      wa_pipe[0]     <= bf_addr_a;
      wb_pipe[0]     <= bf_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        bf_vld_pipe[i] <= bf_vld_pipe[i-1];
        wa_pipe[i]     <= wa_pipe[i-1];
        wb_pipe[i]     <= wb_pipe[i-1];
      end
      rd_vld_pipe[0] <= unload_rd_en;
      for (int i = 1; i < RD_LAT; i++) rd_vld_pipe[i] <= rd_vld_pipe[i-1];
    end
  end

  // load_addr tracks cnt for the whole LOAD phase so it holds across stalls.
  assign load_wr_en   = (state == LOAD) && in_valid;
  assign load_addr    = (state == LOAD) ? bitrev6(cnt) : 6'd0;
  assign bf_rd_en     = (state == COMPUTE);
  assign bf_addr_a    = bf_rd_en ? ga  : 6'd0;
  assign bf_addr_b    = bf_rd_en ? gb  : 6'd0;
  assign tw_idx       = bf_rd_en ? gtw : 5'd0;
  assign bf_wr_en     = bf_vld_pipe[BF_LAT-1];
  assign bf_wr_addr_a = wa_pipe[BF_LAT-1];
  assign bf_wr_addr_b = wb_pipe[BF_LAT-1];
  assign stage        = stage_q;
  assign unload_rd_en = (state == UNLOAD);
  assign unload_addr0 = unload_rd_en ? {cnt[4:0], 1'b0} : 6'd0;
  assign unload_addr1 = unload_rd_en ? {cnt[4:0], 1'b1} : 6'd0;
  assign out_valid    = rd_vld_pipe[RD_LAT-1];
  assign busy         = (state != IDLE);
  assign done         = (state == FLUSH) && (cnt == 6'(RD_LAT - 1));
endmodule
